val2_shift_sequencer: RTL and testbench

Multi-cycle operand-2 engine shared by two requesters: port 0 is the execute stage and port 1 is the load/store address unit. It arbitrates between them round-robin and captures the winner's operands. It then produces the operand-2 value using an iterative shifter that moves at most STEP_MAX bit positions per cycle. Operand-2 semantics match the existing single-cycle generator: S-type sign-extend, rotated 8-bit immediate, or LSL/LSR/ASR/ROR of Rm by shift_imm.

---
 rtl/arm_shift_pkg.sv | 27 ++
 rtl/val2_shift_step.sv | 27 ++
 rtl/val2_shift_sequencer.sv | 141 ++++++++++++++
 tb/tb_val2_shift_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_shift_pkg.sv
// Shared encodings for the operand-2 shift sequencer: shift types, FSM states
// and the bit positions of the fields inside the 12-bit shift-operand.
package arm_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam int SHIFT_IMM_HI = 11;
    localparam int SHIFT_IMM_LO = 7;
    localparam int SHIFT_HI     = 6;
    localparam int SHIFT_LO     = 5;
    localparam int ROT_IMM_HI   = 11;
    localparam int ROT_IMM_LO   = 8;
    localparam int IMM8_HI      = 7;
    localparam int IMM8_LO      = 0;

endpackage

// File: rtl/val2_shift_step.sv
// One iteration of the operand-2 shifter: moves acc by step (0..32) positions
// using the latched shift type.
module val2_shift_step
    import arm_shift_pkg::*;
(
    input  logic [31:0] acc_i,
    input  shift_t      type_i,
    input  logic [5:0]  step_i,
    output logic [31:0] acc_o
);

    logic [63:0] rot_dbl;

    always_comb begin
        // Rotating the doubled word keeps step==32 well defined (identity).
        rot_dbl = {acc_i, acc_i} >> step_i;
        acc_o   = acc_i;
        case (type_i)
            SH_LSL:  acc_o = acc_i << step_i;
            SH_LSR:  acc_o = acc_i >> step_i;
            SH_ASR:  acc_o = $signed(acc_i) >>> step_i;
            SH_ROR:  acc_o = rot_dbl[31:0];
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle operand-2 engine shared by execute (port 0) and the load/store
// address unit (port 1); round-robin arbitration plus an iterative shifter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | arbitrate, capture winner's operands into acc/rem/type
// ST_SHIFT | shift acc by min(rem, STEP_MAX) per cycle until rem reaches 0
// ST_DONE  | done[owner] and result presented; record owner as last grant
module val2_shift_sequencer
    import arm_shift_pkg::*;
#(
    parameter int STEP_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] p0_val_rm_i,
    input  logic [31:0] p1_val_rm_i,
    input  logic [11:0] p0_shift_operand_i,
    input  logic [11:0] p1_shift_operand_i,
    input  logic        p0_i_i,
    input  logic        p1_i_i,
    input  logic        p0_s_i,
    input  logic        p1_s_i,
    output logic [1:0]  done_o,
    output logic [31:0] result_o,
    output logic        busy_o
);

    localparam logic [5:0] STEP_MAX_W = 6'(STEP_MAX);

    seq_state_t  state_q;
    logic        owner_q;
    logic        last_grant_q;
    shift_t      type_q;
    logic [31:0] acc_q;
    logic [4:0]  rem_q;
    logic [1:0]  done_q;
    logic [31:0] result_q;

    logic        gnt_d;
    logic [31:0] sel_rm_d;
    logic [11:0] sel_so_d;
    logic        sel_i_d;
    logic        sel_s_d;
    logic [31:0] cap_acc_d;
    shift_t      cap_type_d;
    logic [4:0]  cap_rem_d;
    logic [5:0]  step_d;
    logic [31:0] acc_d;

    always_comb begin
        // The port not granted last wins a tie; a lone requester always wins.
        if (req_i[0] && req_i[1]) begin
            gnt_d = ~last_grant_q;
        end else begin
            gnt_d = req_i[1] & ~req_i[0];
        end

        sel_rm_d = gnt_d ? p1_val_rm_i        : p0_val_rm_i;
        sel_so_d = gnt_d ? p1_shift_operand_i : p0_shift_operand_i;
        sel_i_d  = gnt_d ? p1_i_i             : p0_i_i;
        sel_s_d  = gnt_d ? p1_s_i             : p0_s_i;

        cap_acc_d  = sel_rm_d;
        cap_type_d = shift_t'(sel_so_d[SHIFT_HI:SHIFT_LO]);
        cap_rem_d  = sel_so_d[SHIFT_IMM_HI:SHIFT_IMM_LO];
        if (sel_s_d) begin
            cap_acc_d  = {{20{sel_so_d[11]}}, sel_so_d};
            cap_type_d = SH_LSL;
            cap_rem_d  = 5'd0;
        end else if (sel_i_d) begin
            cap_acc_d  = {24'b0, sel_so_d[IMM8_HI:IMM8_LO]};
            cap_type_d = SH_ROR;
            cap_rem_d  = {sel_so_d[ROT_IMM_HI:ROT_IMM_LO], 1'b0};
        end

        step_d = ({1'b0, rem_q} < STEP_MAX_W) ? {1'b0, rem_q} : STEP_MAX_W;
    end

    val2_shift_step u_step (
        .acc_i  (acc_q),
        .type_i (type_q),
        .step_i (step_d),
        .acc_o  (acc_d)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            type_q       <= SH_LSL;
            acc_q        <= 32'd0;
            rem_q        <= 5'd0;
            done_q       <= 2'b00;
            result_q     <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        owner_q <= gnt_d;
                        type_q  <= cap_type_d;
                        acc_q   <= cap_acc_d;
                        rem_q   <= cap_rem_d;
                        if (cap_rem_d == 5'd0) begin
                            result_q <= cap_acc_d;
                            done_q   <= gnt_d ? 2'b10 : 2'b01;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_q - step_d[4:0];
                    if ({1'b0, rem_q} == step_d) begin
                        result_q <= acc_d;
                        done_q   <= owner_q ? 2'b10 : 2'b01;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q       <= 2'b00;
                    last_grant_q <= owner_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    done_q  <= 2'b00;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Scoreboard bench for val2_shift_sequencer: drivers push expected results per
// port, a negedge monitor pops and compares whenever a done bit is seen.
module tb_val2_shift_sequencer;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] rm_a [2];
    logic [11:0] so_a [2];
    logic        i_a  [2];
    logic        s_a  [2];
    logic [1:0]  done;
    logic [31:0] result;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   done_log[$];

    val2_shift_sequencer #(.STEP_MAX(8)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .req_i              (req),
        .p0_val_rm_i        (rm_a[0]),
        .p1_val_rm_i        (rm_a[1]),
        .p0_shift_operand_i (so_a[0]),
        .p1_shift_operand_i (so_a[1]),
        .p0_i_i             (i_a[0]),
        .p1_i_i             (i_a[1]),
        .p0_s_i             (s_a[0]),
        .p1_s_i             (s_a[1]),
        .done_o             (done),
        .result_o           (result),
        .busy_o             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: architectural operand-2 rules, one bit position at a time.
    function automatic int model_amount(logic [11:0] so, bit ii, bit ss);
        if (ss) return 0;
        if (ii) return 2 * int'(so[11:8]);
        return int'(so[11:7]);
    endfunction

    function automatic logic [31:0] model(logic [31:0] rm, logic [11:0] so, bit ii, bit ss);
        int          amt;
        int          ty;
        int          sv;
        logic [31:0] v;
        if (ss) begin
            sv = int'(so);
            if (sv >= 2048) sv = sv - 4096;
            return 32'(sv);
        end
        if (ii) begin
            v  = 32'(so[7:0]);
            ty = 3;
        end else begin
            v  = rm;
            ty = int'(so[6:5]);
        end
        amt = model_amount(so, ii, ss);
        for (int k = 0; k < amt; k++) begin
            case (ty)
                0: v = v * 2;
                1: v = v / 2;
                2: v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    function automatic int model_latency(logic [11:0] so, bit ii, bit ss);
        return 1 + (model_amount(so, ii, ss) + 7) / 8;
    endfunction

    function automatic logic [11:0] reg_so(int amt, int ty);
        logic [11:0] so;
        so = 12'd0;
        so[11:7] = 5'(amt);
        so[6:5]  = 2'(ty);
        return so;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done != 2'b00) begin
                checks++;
                if (done == 2'b11) begin
                    errors++;
                    $display("FAIL done_exclusive: done=%b required one-hot", done);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    exp_t e;
                    bit   have;
                    done_log.push_back(p);
                    have = 1'b0;
                    if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL unexpected_done: port %0d done with result %h, nothing pending", p, result);
                    end else begin
                        if (result !== e.res) begin
                            errors++;
                            $display("FAIL result_p%0d: got %h required %h", p, result, e.res);
                        end
                        if (e.cyc >= 0) begin
                            checks++;
                            if (cyc != e.cyc) begin
                                errors++;
                                $display("FAIL latency_p%0d: done at cycle %0d required %0d", p, cyc, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int p, input logic [31:0] res, input int c);
        exp_t e;
        e.res = res;
        e.cyc = c;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called just after a negedge in the cycle that should sample the request.
    task automatic issue(input int p, input logic [31:0] r, input logic [11:0] so,
                         input bit ii, input bit ss, input logic [31:0] want,
                         input bit track, input bit scramble);
        bit seen;
        rm_a[p] = r;
        so_a[p] = so;
        i_a[p]  = ii;
        s_a[p]  = ss;
        push_exp(p, want, track ? cyc + model_latency(so, ii, ss) : -1);
        req[p] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (scramble && n == 0) begin
                rm_a[p] = $urandom;
                so_a[p] = 12'($urandom);
                i_a[p]  = 1'($urandom);
                s_a[p]  = 1'($urandom);
            end
            if (done[p]) seen = 1'b1;
        end
        req[p] = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_p%0d: no done within 60 cycles, required one", p);
        end
    endtask

    task automatic run_random(input int p, input int nops);
        logic [31:0] r;
        logic [11:0] so;
        bit          ii;
        bit          ss;
        for (int k = 0; k < nops; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r  = $urandom;
            so = 12'($urandom);
            ss = ($urandom_range(0, 3) == 0);
            ii = 1'($urandom);
            issue(p, r, so, ii, ss, model(r, so, ii, ss), 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    initial begin
        int base;
        int n;
        req   = 2'b00;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rm_a[p] = 32'd0; so_a[p] = 12'd0; i_a[p] = 1'b0; s_a[p] = 1'b0;
        end
        #12;
        check_val("reset_busy",   32'(busy),   32'd0);
        check_val("reset_done",   32'(done),   32'd0);
        check_val("reset_result", result,      32'd0);

        // Both ports requesting from reset: strict alternation starting with port 0.
        so_a[0] = 12'h005; s_a[0] = 1'b1;
        so_a[1] = 12'h7FF; s_a[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 32'h0000_0005, -1);
            push_exp(1, 32'h0000_07FF, -1);
        end
        req = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (done_log.size() < 6 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        req = 2'b00;
        check_val("arb_count", 32'(done_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < done_log.size(); k++)
            check_val($sformatf("arb_order_%0d", k), 32'(done_log[k]), 32'(k % 2));

        // Directed single-port operations with exact latency.
        @(negedge clk); @(negedge clk);
        issue(0, 32'h0000_0001, reg_so(4, 0), 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b1);
        @(negedge clk);
        issue(0, 32'h8000_0000, reg_so(31, 2), 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        @(negedge clk);
        issue(0, 32'hDEAD_BEEF, 12'h1FF, 1'b1, 1'b0, 32'hC000_003F, 1'b1, 1'b1);
        @(negedge clk);
        issue(1, 32'h1111_1111, 12'h800, 1'b0, 1'b1, 32'hFFFF_F800, 1'b1, 1'b1);
        @(negedge clk);
        issue(1, 32'h1234_5678, reg_so(0, 3), 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
        @(negedge clk);
        issue(1, 32'hF000_0000, reg_so(9, 1), 1'b0, 1'b0, 32'h0078_0000, 1'b1, 1'b1);
        @(negedge clk);
        issue(1, 32'h8765_4321, reg_so(17, 3), 1'b0, 1'b0, 32'hA190_C3B2, 1'b1, 1'b1);
        @(negedge clk);
        // Leaves last_grant at port 0 so the reset test shows it is restored.
        issue(0, 32'h0, 12'h123, 1'b0, 1'b1, 32'h0000_0123, 1'b1, 1'b0);
        @(negedge clk);

        // Reset in the middle of a long ASR: nothing completes, outputs clear at once.
        rm_a[0] = 32'h8000_0000; so_a[0] = reg_so(31, 2); i_a[0] = 1'b0; s_a[0] = 1'b0;
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_busy",   32'(busy), 32'd0);
        check_val("rst_done",   32'(done), 32'd0);
        check_val("rst_result", result,    32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = done_log.size();
        so_a[0] = 12'h00A; s_a[0] = 1'b1; i_a[0] = 1'b0;
        so_a[1] = 12'h00B; s_a[1] = 1'b1; i_a[1] = 1'b0;
        push_exp(0, 32'h0000_000A, -1);
        push_exp(1, 32'h0000_000B, -1);
        req = 2'b11;
        n = 0;
        while (req != 2'b00 && n < 20) begin
            @(negedge clk); #1;
            if (done[0]) req[0] = 1'b0;
            if (done[1]) req[1] = 1'b0;
            n++;
        end
        req = 2'b00;
        check_val("post_rst_count", 32'(done_log.size() - base), 32'd2);
        if (done_log.size() > base)
            check_val("post_rst_first", 32'(done_log[base]), 32'd0);

        // Randomised concurrent traffic on both ports.
        @(negedge clk);
        fork
            run_random(0, 30);
            run_random(1, 30);
        join
        repeat (4) @(negedge clk);
        check_val("pending_p0", 32'(q0.size()), 32'd0);
        check_val("pending_p1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
